// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the parametrised flagged FIFO.
// Parameter validity is checked at elaboration through params_ok().
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic pnding;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int af_lvl, input int ae_lvl);
    return is_pow2(depth)
        && (af_lvl >= 1) && (af_lvl <= depth)
        && (ae_lvl >= 0) && (ae_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// Producer/consumer bundle of the flagged FIFO; clock and reset stay plain ports.
interface fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) ();

  logic                      push_i;
  logic [BITS-1:0]           data_i;
  logic                      pop_i;
  logic                      clr_err_i;
  logic [BITS-1:0]           data_o;
  logic                      full_o;
  logic                      pnding_o;
  logic                      almost_full_o;
  logic                      almost_empty_o;
  logic [cnt_w(DEPTH)-1:0]   count_o;
  logic                      overflow_o;
  logic                      underflow_o;

  modport master (
    output push_i, data_i, pop_i, clr_err_i,
    input  data_o, full_o, pnding_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, data_i, pop_i, clr_err_i,
    output data_o, full_o, pnding_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_flags_ctrl.sv
// Pointer, occupancy and flag bookkeeping for fifo_flags_top.
// Everything visible on the status outputs comes straight from registers.
module fifo_flags_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    clr_err_i,
  output logic                    we_o,
  output logic [ptr_w(DEPTH)-1:0] wr_ptr_o,
  output logic [ptr_w(DEPTH)-1:0] rd_ptr_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output fifo_status_t            status_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!params_ok(DEPTH, AF_LVL, AE_LVL)) begin : g_bad_params
    $error("fifo_flags_ctrl: DEPTH must be a power of two >= 2, AF_LVL in 1..DEPTH, AE_LVL in 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full, pnding, push_acc, pop_acc;

  assign full   = (count_q == CW'(DEPTH));
  assign pnding = (count_q != '0);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    pop_acc  = pop_i && pnding;
    // A pop on a full FIFO frees the very slot the write pointer aims at.
    push_acc = push_i && (!full || pop_acc);

    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle error wins over the clear.
    if (clr_err_i)           overflow_d  = 1'b0;
    if (clr_err_i)           underflow_d = 1'b0;
    if (push_i && !push_acc) overflow_d  = 1'b1;
    if (pop_i && !pop_acc)   underflow_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign we_o     = push_acc;
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

  always_comb begin
    status_o              = '0;
    status_o.full         = full;
    status_o.pnding       = pnding;
    status_o.almost_full  = (count_q >= CW'(AF_LVL));
    status_o.almost_empty = (count_q <= CW'(AE_LVL));
    status_o.overflow     = overflow_q;
    status_o.underflow    = underflow_q;
  end

endmodule

// File: rtl/fifo_flags_top.sv
// First-word-fall-through register-array FIFO with thresholds and sticky error flags.
// Holds the storage and the output mux; bookkeeping lives in fifo_flags_ctrl.
module fifo_flags_top
  import fifo_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fifo_flags_if.slave  bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (BITS < 1) begin : g_bad_bits
    $error("fifo_flags_top: BITS must be at least 1");
  end

  logic               we;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  fifo_status_t       status;
  logic [BITS-1:0]    mem_q [DEPTH];

  fifo_flags_ctrl #(
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) u_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (bus.push_i),
    .pop_i     (bus.pop_i),
    .clr_err_i (bus.clr_err_i),
    .we_o      (we),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count),
    .status_o  (status)
  );

  // NOTE: storage has no reset; stale words are harmless because data_o is gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_ptr] <= bus.data_i;
  end

  assign bus.data_o         = status.pnding ? mem_q[rd_ptr] : '0;
  assign bus.count_o        = count;
  assign bus.full_o         = status.full;
  assign bus.pnding_o       = status.pnding;
  assign bus.almost_full_o  = status.almost_full;
  assign bus.almost_empty_o = status.almost_empty;
  assign bus.overflow_o     = status.overflow;
  assign bus.underflow_o    = status.underflow;

endmodule

// File: tb/tb_fifo_flags_top.sv
// Directed plus model-checked random bench for fifo_flags_top (DEPTH=4, BITS=32, AF=3, AE=1).
module tb_fifo_flags_top;

  localparam int BITS   = 32;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;
  localparam int AE_LVL = 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  fifo_flags_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  fifo_flags_top #(
    .BITS   (BITS),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Threshold flags follow from the expected count with AF=3, AE=1.
  task automatic check_state(input string tag, input logic [31:0] exp_data, input int exp_cnt,
                             input logic exp_ovf, input logic exp_udf);
    check({tag, " data"},   bus.data_o, exp_data);
    check({tag, " count"},  bus.count_o, exp_cnt);
    check({tag, " full"},   bus.full_o, exp_cnt == DEPTH);
    check({tag, " pnding"}, bus.pnding_o, exp_cnt != 0);
    check({tag, " af"},     bus.almost_full_o, exp_cnt >= AF_LVL);
    check({tag, " ae"},     bus.almost_empty_o, exp_cnt <= AE_LVL);
    check({tag, " ovf"},    bus.overflow_o, exp_ovf);
    check({tag, " udf"},    bus.underflow_o, exp_udf);
  endtask

  // Inputs are applied 1 time unit after an edge and sampled by the next one.
  task automatic drive(input logic push, input logic [31:0] data, input logic pop, input logic clr);
    bus.push_i    = push;
    bus.data_i    = data;
    bus.pop_i     = pop;
    bus.clr_err_i = clr;
    @(posedge clk_i);
    #1;
    bus.push_i    = 1'b0;
    bus.pop_i     = 1'b0;
    bus.clr_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  logic [31:0] mq[$];
  logic        m_ovf, m_udf;

  initial begin
    bus.push_i    = 1'b0;
    bus.data_i    = '0;
    bus.pop_i     = 1'b0;
    bus.clr_err_i = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset();
    check_state("reset", 32'h0, 0, 1'b0, 1'b0);

    // 1: fill, data_o stays on the first word
    drive(1'b1, 32'hA, 1'b0, 1'b0); check_state("fill1", 32'hA, 1, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0); check_state("fill2", 32'hA, 2, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0); check_state("fill3", 32'hA, 3, 1'b0, 1'b0);
    drive(1'b1, 32'hD, 1'b0, 1'b0); check_state("fill4", 32'hA, 4, 1'b0, 1'b0);

    // 2: overflow, drain, underflow, clear
    drive(1'b1, 32'hE, 1'b0, 1'b0); check_state("ovf",    32'hA, 4, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("drain1", 32'hB, 3, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("drain2", 32'hC, 2, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("drain3", 32'hD, 1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("drain4", 32'h0, 0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("udf",    32'h0, 0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1); check_state("clr",    32'h0, 0, 1'b0, 1'b0);

    // 3: push+pop on full writes the freed slot, exercising wrap-around
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hD, 1'b0, 1'b0); check_state("refill", 32'hA, 4, 1'b0, 1'b0);
    drive(1'b1, 32'h10, 1'b1, 1'b0); check_state("fullpp", 32'hB, 4, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("wrap1", 32'hC, 3, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("wrap2", 32'hD, 2, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("wrap3", 32'h10, 1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("wrap4", 32'h0, 0, 1'b0, 1'b0);

    // 4: push+pop on empty: pop rejected, push accepted, no pass-through
    drive(1'b1, 32'h55, 1'b1, 1'b0); check_state("emptypp", 32'h55, 1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1);  check_state("emptyclr", 32'h0, 0, 1'b0, 1'b0);

    // 5: reset while half full (with a sticky flag set) discards everything
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h3, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h5, 1'b0, 1'b0); check_state("half_ovf", 32'h1, 4, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); check_state("half", 32'h3, 2, 1'b1, 1'b0);
    do_reset();                      check_state("midrst", 32'h0, 0, 1'b0, 1'b0);
    drive(1'b1, 32'h77, 1'b0, 1'b0); check_state("postrst", 32'h77, 1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);  check_state("postrst_pop", 32'h0, 0, 1'b0, 1'b0);

    // 6: random traffic against a queue model, compared every cycle
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic        push, pop, clr, pop_acc, push_acc;
      logic [31:0] data;
      push = ($urandom_range(0, 99) < 55);
      pop  = ($urandom_range(0, 99) < 50);
      clr  = ($urandom_range(0, 15) == 0);
      data = $urandom;
      pop_acc  = pop && (mq.size() != 0);
      push_acc = push && ((mq.size() != DEPTH) || pop_acc);
      if (pop_acc)  void'(mq.pop_front());
      if (push_acc) mq.push_back(data);
      if (clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (push && !push_acc) m_ovf = 1'b1;
      if (pop && !pop_acc)   m_udf = 1'b1;
      drive(push, data, pop, clr);
      check_state($sformatf("rnd%0d", i), (mq.size() != 0) ? mq[0] : 32'h0,
                  mq.size(), m_ovf, m_udf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
